// File: rtl/even_pipe_sched_pkg.sv
// ----------------------------------------------------------------------------
// even_pipe_sched_pkg
//   Shared types and constants for the even-pipe result-staging scheduler:
//   stage numbering, the per-stage record, latency classes and the
//   latency-clamp helper used at issue capture.
// ----------------------------------------------------------------------------
package even_pipe_sched_pkg;

  localparam int EP_FIRST_STG = 2;
  localparam int EP_LAST_STG  = 7;
  localparam int EP_NUM_STG   = EP_LAST_STG - EP_FIRST_STG + 1;

  localparam int EP_ADDR_W = 7;
  localparam int EP_DATA_W = 128;
  localparam int EP_LAT_W  = 3;

  // Latency classes: cycles from issue until the result is forwardable.
  localparam int LAT_SIMPLE_FIXED = 2;
  localparam int LAT_BYTE         = 4;
  localparam int LAT_SP_FP        = 6;
  localparam int LAT_FP_INT       = 7;

  typedef struct packed {
    logic                 vld;
    logic                 wr_en;
    logic [EP_LAT_W-1:0]  lat;
    logic [EP_ADDR_W-1:0] addr;
    logic [EP_DATA_W-1:0] data;
  } ep_stage_t;

  // A result can never be forwardable before it reaches the first stage,
  // so latency classes 0 and 1 are stored as 2.
  function automatic logic [EP_LAT_W-1:0] clamp_lat(input logic [EP_LAT_W-1:0] lat);
    if (lat < EP_LAT_W'(EP_FIRST_STG)) begin
      return EP_LAT_W'(EP_FIRST_STG);
    end
    return lat;
  endfunction

endpackage

// File: rtl/even_pipe_sched_hazard_chk.sv
// ----------------------------------------------------------------------------
// ep_hazard_chk
//   Combinational RAW check of the issuing instruction's three sources
//   against every in-flight stage whose result is not yet forwardable.
// Ports:
//   stg_live  : per stage, entry is valid and writes its destination
//   stg_lat   : per stage, stored (clamped) latency class
//   stg_addr  : per stage, destination register
//   src_ra/rb/rc, src_used : sources of the issuing instruction, {rc,rb,ra}
//   stall     : some used source depends on a not-yet-forwardable result
// Index i of the stage vectors corresponds to pipeline stage i+2.
// ----------------------------------------------------------------------------
module ep_hazard_chk
  import even_pipe_sched_pkg::*;
(
  input  logic [EP_NUM_STG-1:0]                stg_live,
  input  logic [EP_NUM_STG-1:0][EP_LAT_W-1:0]  stg_lat,
  input  logic [EP_NUM_STG-1:0][EP_ADDR_W-1:0] stg_addr,
  input  logic [EP_ADDR_W-1:0]                 src_ra,
  input  logic [EP_ADDR_W-1:0]                 src_rb,
  input  logic [EP_ADDR_W-1:0]                 src_rc,
  input  logic [2:0]                           src_used,
  output logic                                 stall
);

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < EP_NUM_STG; i++) begin
      // Not forwardable while the stage number is still below the latency.
      if (stg_live[i] && (stg_lat[i] > EP_LAT_W'(i + EP_FIRST_STG))) begin
        if ((src_used[0] && (stg_addr[i] == src_ra)) ||
            (src_used[1] && (stg_addr[i] == src_rb)) ||
            (src_used[2] && (stg_addr[i] == src_rc))) begin
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/even_pipe_sched.sv
// ----------------------------------------------------------------------------
// even_pipe_sched
//   Result-staging scheduler for the even pipe. Captures one issued result
//   per cycle into stage 2, shifts it unconditionally through stage 7,
//   exposes per-stage forwarding taps and retires to the register file at
//   stage 7. Issue is held off while a used source matches an in-flight
//   result that is not yet forwardable, and while flush is asserted.
// Ports:
//   clk, rst (async, active high)
//   issue_valid/issue_ready, issue_wr_en, issue_rt_addr, issue_rt_data,
//   issue_lat, src_ra/rb/rc, src_used : issue slot
//   flush          : squash stages 2..6 on the next edge, drop any issue
//   rf_addr_sN / rf_data_sN / fwd_vld_sN (N=2..7) : forwarding taps
//   rt_wr_en_ep / rt_addr_ep / rt_data_ep          : register-file write
//   stall_cnt      : saturating count of stalled issue cycles
// ----------------------------------------------------------------------------
module even_pipe_sched
  import even_pipe_sched_pkg::*;
#(
  parameter int REG_ADDR_WD = EP_ADDR_W,
  parameter int REG_DATA_WD = EP_DATA_W,
  parameter int LAT_WD      = EP_LAT_W,
  parameter int CNT_WD      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic                   issue_wr_en,
  input  logic [REG_ADDR_WD-1:0] issue_rt_addr,
  input  logic [REG_DATA_WD-1:0] issue_rt_data,
  input  logic [LAT_WD-1:0]      issue_lat,
  input  logic [REG_ADDR_WD-1:0] src_ra,
  input  logic [REG_ADDR_WD-1:0] src_rb,
  input  logic [REG_ADDR_WD-1:0] src_rc,
  input  logic [2:0]             src_used,
  input  logic                   flush,
  output logic [REG_ADDR_WD-1:0] rf_addr_s2,
  output logic [REG_ADDR_WD-1:0] rf_addr_s3,
  output logic [REG_ADDR_WD-1:0] rf_addr_s4,
  output logic [REG_ADDR_WD-1:0] rf_addr_s5,
  output logic [REG_ADDR_WD-1:0] rf_addr_s6,
  output logic [REG_ADDR_WD-1:0] rf_addr_s7,
  output logic [REG_DATA_WD-1:0] rf_data_s2,
  output logic [REG_DATA_WD-1:0] rf_data_s3,
  output logic [REG_DATA_WD-1:0] rf_data_s4,
  output logic [REG_DATA_WD-1:0] rf_data_s5,
  output logic [REG_DATA_WD-1:0] rf_data_s6,
  output logic [REG_DATA_WD-1:0] rf_data_s7,
  output logic                   fwd_vld_s2,
  output logic                   fwd_vld_s3,
  output logic                   fwd_vld_s4,
  output logic                   fwd_vld_s5,
  output logic                   fwd_vld_s6,
  output logic                   fwd_vld_s7,
  output logic                   rt_wr_en_ep,
  output logic [REG_ADDR_WD-1:0] rt_addr_ep,
  output logic [REG_DATA_WD-1:0] rt_data_ep,
  output logic [CNT_WD-1:0]      stall_cnt
);

  ep_stage_t stg_q [EP_FIRST_STG:EP_LAST_STG];
  ep_stage_t stg_d [EP_FIRST_STG:EP_LAST_STG];

  logic [CNT_WD-1:0] stall_cnt_q;
  logic [CNT_WD-1:0] stall_cnt_d;

  logic [EP_NUM_STG-1:0]                hz_live;
  logic [EP_NUM_STG-1:0][EP_LAT_W-1:0]  hz_lat;
  logic [EP_NUM_STG-1:0][EP_ADDR_W-1:0] hz_addr;
  logic                                 hz_stall;
  logic [EP_NUM_STG-1:0]                fwd_vld;

  always_comb begin
    hz_live = '0;
    hz_lat  = '0;
    hz_addr = '0;
    fwd_vld = '0;
    for (int i = 0; i < EP_NUM_STG; i++) begin
      hz_live[i] = stg_q[i + EP_FIRST_STG].vld && stg_q[i + EP_FIRST_STG].wr_en;
      hz_lat[i]  = stg_q[i + EP_FIRST_STG].lat;
      hz_addr[i] = stg_q[i + EP_FIRST_STG].addr;
      fwd_vld[i] = hz_live[i] && (EP_LAT_W'(i + EP_FIRST_STG) >= stg_q[i + EP_FIRST_STG].lat);
    end
  end

  ep_hazard_chk u_hazard_chk (
    .stg_live (hz_live),
    .stg_lat  (hz_lat),
    .stg_addr (hz_addr),
    .src_ra   (src_ra),
    .src_rb   (src_rb),
    .src_rc   (src_rc),
    .src_used (src_used),
    .stall    (hz_stall)
  );

  // Ready is independent of issue_valid so decode can look ahead.
  assign issue_ready = !hz_stall && !flush;

  always_comb begin
    stg_d[EP_FIRST_STG] = '0;
    if (issue_valid && issue_ready) begin
      stg_d[EP_FIRST_STG].vld   = 1'b1;
      stg_d[EP_FIRST_STG].wr_en = issue_wr_en;
      stg_d[EP_FIRST_STG].lat   = clamp_lat(issue_lat);
      stg_d[EP_FIRST_STG].addr  = issue_rt_addr;
      stg_d[EP_FIRST_STG].data  = issue_rt_data;
    end
    // Unconditional shift; flush kills everything that has not reached s7.
    for (int n = EP_FIRST_STG + 1; n <= EP_LAST_STG; n++) begin
      stg_d[n] = stg_q[n-1];
      if (flush) begin
        stg_d[n].vld = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_valid && !issue_ready && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WD'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = EP_FIRST_STG; n <= EP_LAST_STG; n++) begin
        stg_q[n] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int n = EP_FIRST_STG; n <= EP_LAST_STG; n++) begin
        stg_q[n] <= stg_d[n];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rf_addr_s2 = stg_q[2].addr;
  assign rf_addr_s3 = stg_q[3].addr;
  assign rf_addr_s4 = stg_q[4].addr;
  assign rf_addr_s5 = stg_q[5].addr;
  assign rf_addr_s6 = stg_q[6].addr;
  assign rf_addr_s7 = stg_q[7].addr;

  assign rf_data_s2 = stg_q[2].data;
  assign rf_data_s3 = stg_q[3].data;
  assign rf_data_s4 = stg_q[4].data;
  assign rf_data_s5 = stg_q[5].data;
  assign rf_data_s6 = stg_q[6].data;
  assign rf_data_s7 = stg_q[7].data;

  assign fwd_vld_s2 = fwd_vld[0];
  assign fwd_vld_s3 = fwd_vld[1];
  assign fwd_vld_s4 = fwd_vld[2];
  assign fwd_vld_s5 = fwd_vld[3];
  assign fwd_vld_s6 = fwd_vld[4];
  assign fwd_vld_s7 = fwd_vld[5];

  assign rt_wr_en_ep = stg_q[7].vld && stg_q[7].wr_en;
  assign rt_addr_ep  = stg_q[7].addr;
  assign rt_data_ep  = stg_q[7].data;

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_even_pipe_sched.sv
module tb_even_pipe_sched;

  logic         clk;
  logic         rst;
  logic         issue_valid;
  logic         issue_ready;
  logic         issue_wr_en;
  logic [6:0]   issue_rt_addr;
  logic [127:0] issue_rt_data;
  logic [2:0]   issue_lat;
  logic [6:0]   src_ra, src_rb, src_rc;
  logic [2:0]   src_used;
  logic         flush;
  logic [6:0]   rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7;
  logic [127:0] rf_data_s2, rf_data_s3, rf_data_s4, rf_data_s5, rf_data_s6, rf_data_s7;
  logic         fwd_vld_s2, fwd_vld_s3, fwd_vld_s4, fwd_vld_s5, fwd_vld_s6, fwd_vld_s7;
  logic         rt_wr_en_ep;
  logic [6:0]   rt_addr_ep;
  logic [127:0] rt_data_ep;
  logic [15:0]  stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  even_pipe_sched dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_wr_en(issue_wr_en), .issue_rt_addr(issue_rt_addr),
    .issue_rt_data(issue_rt_data), .issue_lat(issue_lat),
    .src_ra(src_ra), .src_rb(src_rb), .src_rc(src_rc), .src_used(src_used),
    .flush(flush),
    .rf_addr_s2(rf_addr_s2), .rf_addr_s3(rf_addr_s3), .rf_addr_s4(rf_addr_s4),
    .rf_addr_s5(rf_addr_s5), .rf_addr_s6(rf_addr_s6), .rf_addr_s7(rf_addr_s7),
    .rf_data_s2(rf_data_s2), .rf_data_s3(rf_data_s3), .rf_data_s4(rf_data_s4),
    .rf_data_s5(rf_data_s5), .rf_data_s6(rf_data_s6), .rf_data_s7(rf_data_s7),
    .fwd_vld_s2(fwd_vld_s2), .fwd_vld_s3(fwd_vld_s3), .fwd_vld_s4(fwd_vld_s4),
    .fwd_vld_s5(fwd_vld_s5), .fwd_vld_s6(fwd_vld_s6), .fwd_vld_s7(fwd_vld_s7),
    .rt_wr_en_ep(rt_wr_en_ep), .rt_addr_ep(rt_addr_ep), .rt_data_ep(rt_data_ep),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs then change 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid   = 1'b0;
    issue_wr_en   = 1'b0;
    issue_rt_addr = '0;
    issue_rt_data = '0;
    issue_lat     = 3'd2;
    src_ra        = '0;
    src_rb        = '0;
    src_rc        = '0;
    src_used      = 3'b000;
    flush         = 1'b0;
  endtask

  task automatic set_issue(input logic wr, input logic [6:0] addr,
                           input logic [127:0] data, input logic [2:0] lat);
    issue_valid   = 1'b1;
    issue_wr_en   = wr;
    issue_rt_addr = addr;
    issue_rt_data = data;
    issue_lat     = lat;
  endtask

  logic [127:0] pat_a5;
  logic [127:0] pat_3c;

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_3c = {16{8'h3C}};
    idle_inputs();
    rst = 1'b1;
    #12;
    // Reset state
    check_val("rst_rt_wr_en", rt_wr_en_ep, 0);
    check_val("rst_rt_addr", rt_addr_ep, 0);
    check_val("rst_fwd_s2", fwd_vld_s2, 0);
    check_val("rst_data_s7", rf_data_s7, 0);
    check_val("rst_stall_cnt", stall_cnt, 0);
    check_val("rst_ready", issue_ready, 1);
    rst = 1'b0;
    step();

    // 1: simple lat=2 write to r5
    set_issue(1'b1, 7'd5, pat_a5, 3'd2);
    #1 check_val("t1_ready", issue_ready, 1);
    step();
    idle_inputs();
    #1;
    check_val("t1_fwd_s2", fwd_vld_s2, 1);
    check_val("t1_addr_s2", rf_addr_s2, 5);
    repeat (4) step();
    check_val("t1_no_early_wr", rt_wr_en_ep, 0);
    step();
    check_val("t1_wr_en", rt_wr_en_ep, 1);
    check_val("t1_wr_addr", rt_addr_ep, 5);
    check_val("t1_wr_data", rt_data_ep, pat_a5);
    check_val("t1_fwd_s7", fwd_vld_s7, 1);
    step();
    check_val("t1_wr_done", rt_wr_en_ep, 0);

    // 2: lat=6 producer to r9, dependent consumer stalls 4 cycles
    set_issue(1'b1, 7'd9, pat_3c, 3'd6);
    #1 check_val("t2_prod_ready", issue_ready, 1);
    step();
    set_issue(1'b0, 7'd0, 128'h0, 3'd2);
    src_ra   = 7'd9;
    src_used = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1 check_val($sformatf("t2_stall_%0d", k), issue_ready, 0);
      check_val($sformatf("t2_fwd_s%0d", k + 2), (k == 0) ? fwd_vld_s2 : (k == 1) ? fwd_vld_s3 :
                (k == 2) ? fwd_vld_s4 : fwd_vld_s5, 0);
      step();
    end
    #1;
    check_val("t2_release", issue_ready, 1);
    check_val("t2_fwd_s6", fwd_vld_s6, 1);
    check_val("t2_addr_s6", rf_addr_s6, 9);
    step();
    idle_inputs();
    #1;
    check_val("t2_stall_cnt", stall_cnt, 4);
    check_val("t2_cons_in_s2", rf_addr_s2, 0);
    repeat (3) step();

    // 3: same dependency but ra not in use -> back to back
    set_issue(1'b1, 7'd9, pat_3c, 3'd6);
    #1 check_val("t3_prod_ready", issue_ready, 1);
    step();
    set_issue(1'b1, 7'd20, pat_a5, 3'd2);
    src_ra   = 7'd9;
    src_rb   = 7'd1;
    src_rc   = 7'd2;
    src_used = 3'b110;
    #1 check_val("t3_cons_ready", issue_ready, 1);
    step();
    idle_inputs();
    #1;
    check_val("t3_addr_s2", rf_addr_s2, 20);
    check_val("t3_addr_s3", rf_addr_s3, 9);
    check_val("t3_stall_cnt", stall_cnt, 4);
    // rb used and matching r9 (lat 6, now in s3) must stall
    issue_valid = 1'b1;
    src_rb      = 7'd9;
    src_used    = 3'b010;
    #1 check_val("t3_rb_stall", issue_ready, 0);
    idle_inputs();
    repeat (8) step();

    // 4: fill s2..s7, then flush for one cycle
    for (int k = 0; k < 6; k++) begin
      set_issue(1'b1, 7'(10 + k), 128'(k + 1), 3'd2);
      step();
    end
    idle_inputs();
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_wr_en = 1'b1;
    issue_rt_addr = 7'd99;
    #1;
    check_val("t4_flush_ready", issue_ready, 0);
    check_val("t4_s7_wr", rt_wr_en_ep, 1);
    check_val("t4_s7_addr", rt_addr_ep, 10);
    check_val("t4_s2_addr", rf_addr_s2, 15);
    step();
    idle_inputs();
    #1 check_val("t4_drop_issue", fwd_vld_s2, 0);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("t4_no_wr_%0d", k), rt_wr_en_ep, 0);
      step();
    end
    check_val("t4_stall_cnt", stall_cnt, 4);

    // 5: latency classes 0 and 1 behave as 2
    set_issue(1'b1, 7'd33, pat_a5, 3'd0);
    step();
    set_issue(1'b1, 7'd34, pat_3c, 3'd1);
    #1 check_val("t5_lat0_fwd", fwd_vld_s2, 1);
    step();
    idle_inputs();
    #1;
    check_val("t5_lat1_fwd", fwd_vld_s2, 1);
    check_val("t5_lat1_addr", rf_addr_s2, 34);
    issue_valid = 1'b1;
    src_ra      = 7'd34;
    src_used    = 3'b001;
    #1 check_val("t5_no_stall", issue_ready, 1);
    idle_inputs();
    step();

    // 6: asynchronous reset mid-stream
    set_issue(1'b1, 7'd40, pat_a5, 3'd7);
    step();
    set_issue(1'b1, 7'd41, pat_3c, 3'd2);
    src_ra   = 7'd40;
    src_used = 3'b001;
    step();
    #3 rst = 1'b1;
    #1;
    check_val("t6_fwd_s2", fwd_vld_s2, 0);
    check_val("t6_addr_s3", rf_addr_s3, 0);
    check_val("t6_data_s3", rf_data_s3, 0);
    check_val("t6_rt_wr", rt_wr_en_ep, 0);
    check_val("t6_stall_cnt", stall_cnt, 0);
    check_val("t6_ready", issue_ready, 1);
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    set_issue(1'b1, 7'd7, pat_3c, 3'd2);
    step();
    idle_inputs();
    repeat (5) step();
    check_val("t6_restart_wr", rt_wr_en_ep, 1);
    check_val("t6_restart_addr", rt_addr_ep, 7);
    check_val("t6_restart_data", rt_data_ep, pat_3c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
